// File: rtl/regfile_mc.sv
// regfile_mc: N-entry register file with one write port, two latched read
// ports (A/B operand registers), write-to-read bypass, optional hardwired
// zero register and a per-register pending-write scoreboard.

// One storage cell: data word plus its pending-write (busy) bit.
module regfile_mc_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              mark,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              busy
);
  // Data capture and scoreboard update; a same-cycle mark beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (wr) q <= d;
      if (mark)    busy <= 1'b1;
      else if (wr) busy <= 1'b0;
    end
  end
endmodule

module regfile_mc #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd,
  input  logic              we,
  input  logic [DATA_W-1:0] i_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_rd,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  // The whole index space is decoded; unimplemented slots and the zero
  // register read as constant 0 / never busy, so no range compare is needed
  // on the read side.
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] rview;
  logic [DEPTH-1:0]             bview;
  logic [DEPTH-1:0]             wmask;  // slot is real, writable storage

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i < NUM_REGS && !(ZERO_REG != 0 && i == 0)) begin : g_cell
      logic wr, mark;
      assign wr       = we      && (rd      == ADDR_W'(i));
      assign mark     = mark_en && (mark_rd == ADDR_W'(i));
      assign wmask[i] = 1'b1;
      regfile_mc_cell #(.DATA_W(DATA_W)) u_cell (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr),
        .mark (mark),
        .d    (i_data),
        .q    (rview[i]),
        .busy (bview[i])
      );
    end else begin : g_zero
      assign rview[i] = '0;
      assign bview[i] = 1'b0;
      assign wmask[i] = 1'b0;
    end
  end

  logic [DATA_W-1:0] val_a, val_b;

  // Operand select: array value, overridden by a same-cycle accepted write.
  always_comb begin
    val_a = rview[rs];
    val_b = rview[rt];
    if (BYPASS != 0 && we && rd == rs && wmask[rs]) val_a = i_data;
    if (BYPASS != 0 && we && rd == rt && wmask[rt]) val_b = i_data;
  end

  // A/B operand registers, loaded only when rd_en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_a <= '0;
      out_data_b <= '0;
    end else if (rd_en) begin
      out_data_a <= val_a;
      out_data_b <= val_b;
    end
  end

  assign busy_a   = bview[rs];
  assign busy_b   = bview[rt];
  assign dbg_data = rview[dbg_addr];
endmodule
